// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch and load/store.
// Data wins ties unless fetch has been denied MAX_WAIT cycles in a row.
module mem_port_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter logic [AW-1:0] DATA_BASE = AW'(128),
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   output logic          i_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt;
   logic          starved;
   logic [AW-1:0] data_addr;

   assign starved   = (wait_cnt == WAIT_MAX);
   assign data_addr = d_addr + DATA_BASE;

   // Grants are masked by reset so nothing reaches the memory while rst_n is low.
   always_comb begin
      i_gnt  = 1'b0;
      d_gnt  = 1'b0;
      m_addr = '0;
      m_we   = 1'b0;
      if (rst_n) begin
         if (i_req && (!d_req || starved)) begin
            i_gnt  = 1'b1;
            m_addr = i_addr;
         end else if (d_req) begin
            d_gnt  = 1'b1;
            m_addr = data_addr;
            m_we   = d_we;
         end
      end
   end

   assign i_stall = i_req & ~i_gnt;
   assign m_wdata = d_wdata;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

   // Read strobes line up with the memory's one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         wait_cnt <= '0;
      end else begin
         i_rvalid <= i_gnt;
         d_rvalid <= d_gnt & ~d_we;
         if (i_gnt || !i_req)
            wait_cnt <= '0;
         else if (!starved)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and
// an arbitration model built from the grant and starvation rules.
module tb_mem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MAX_WAIT = 4;
   localparam logic [7:0] DATA_BASE = 8'd128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req, i_gnt, i_rvalid, i_stall;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [AW-1:0] m_addr;
   logic          m_we;
   logic [DW-1:0] m_wdata, m_rdata;

   int checks = 0;
   int failures = 0;
   int starve = 0;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] i_q [$];
   logic [7:0] d_q [$];

   mem_port_arbiter #(.AW(AW), .DW(DW), .DATA_BASE(DATA_BASE), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory the arbiter drives.
   always @(posedge clk) begin
      if (m_we) mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one cycle of requests, checks grants against the model, queues expected read data.
   task automatic applyStimulus(input bit ir, input logic [7:0] ia, input bit dr, input bit dw,
                                input logic [7:0] da, input logic [7:0] wd,
                                output bit gi, output bit gd);
      logic [7:0] pa;
      @(negedge clk);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
      #1;
      gi = ir && (!dr || starve == MAX_WAIT);
      gd = dr && !gi;
      pa = 8'((int'(da) + int'(DATA_BASE)) % 256);
      checkOutput("i_gnt", i_gnt, gi);
      checkOutput("d_gnt", d_gnt, gd);
      checkOutput("m_addr", m_addr, gi ? ia : (gd ? pa : 8'h00));
      checkOutput("m_we", m_we, gd && dw);
      checkOutput("i_stall", i_stall, ir && !gi);
      if (gd && dw) checkOutput("m_wdata", m_wdata, wd);
      if (gi) i_q.push_back(ref_mem[ia]);
      if (gd) begin
         if (dw) ref_mem[pa] = wd;
         else d_q.push_back(ref_mem[pa]);
      end
      starve = (gi || !ir) ? 0 : ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT);
   endtask

   // Monitor: every read strobe must match the oldest outstanding expected word.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (i_rvalid === 1'b1) begin
            if (i_q.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL i_rvalid_extra: got strobe expected none");
            end else checkOutput("i_rdata", i_rdata, i_q.pop_front());
         end
         if (d_rvalid === 1'b1) begin
            if (d_q.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL d_rvalid_extra: got strobe expected none");
            end else checkOutput("d_rdata", d_rdata, d_q.pop_front());
         end
      end
   end

   initial begin
      bit gi, gd, ip, dp, dw;
      logic [7:0] ia, da, wd;
      for (int a = 0; a < 256; a++) begin
         mem[a] = 8'($urandom);
         ref_mem[a] = mem[a];
      end
      mem[8'h05] = 8'hA3;
      ref_mem[8'h05] = 8'hA3;

      rst_n = 1'b0;
      i_req = 1'b1; i_addr = 8'h05; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h00;
      #12;
      checkOutput("rst_i_gnt", i_gnt, 0);
      checkOutput("rst_d_gnt", d_gnt, 0);
      checkOutput("rst_m_we", m_we, 0);
      checkOutput("rst_m_addr", m_addr, 0);
      checkOutput("rst_i_stall", i_stall, 1);
      checkOutput("rst_i_rvalid", i_rvalid, 0);
      checkOutput("rst_d_rvalid", d_rvalid, 0);
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;

      $display("[TB] directed fetch");
      applyStimulus(1, 8'h05, 0, 0, 8'h00, 8'h00, gi, gd);
      checkOutput("t1_m_addr", m_addr, 8'h05);
      @(posedge clk); #1;
      checkOutput("t1_i_rvalid", i_rvalid, 1);
      checkOutput("t1_i_rdata", i_rdata, 8'hA3);

      $display("[TB] directed store");
      applyStimulus(0, 8'h00, 1, 1, 8'h10, 8'h5C, gi, gd);
      checkOutput("t2_m_addr", m_addr, 8'h90);
      checkOutput("t2_m_we", m_we, 1);
      @(posedge clk); #1;
      checkOutput("t2_d_rvalid", d_rvalid, 0);
      checkOutput("t2_mem", mem[8'h90], 8'h5C);

      $display("[TB] directed wrapping load");
      applyStimulus(0, 8'h00, 1, 0, 8'hC8, 8'h00, gi, gd);
      checkOutput("t3_m_addr", m_addr, 8'h48);
      @(posedge clk); #1;
      checkOutput("t3_d_rvalid", d_rvalid, 1);
      checkOutput("t3_i_rvalid", i_rvalid, 0);

      $display("[TB] contention starvation pattern");
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00, gi, gd);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1, 8'h33, 1, 0, 8'(k), 8'h00, gi, gd);
         checkOutput("t4_pattern", i_gnt, (k == 4 || k == 9));
      end

      $display("[TB] reset mid-operation");
      for (int k = 0; k < 3; k++) applyStimulus(1, 8'h21, 1, 1, 8'(k), 8'(k), gi, gd);
      @(negedge clk);
      i_req = 1'b1; i_addr = 8'h21; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h07;
      #1;
      checkOutput("t5_d_gnt_pre", d_gnt, 1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t5_d_gnt_rst", d_gnt, 0);
      checkOutput("t5_i_stall_rst", i_stall, 1);
      @(posedge clk); #1;
      checkOutput("t5_d_rvalid", d_rvalid, 0);
      checkOutput("t5_i_rvalid", i_rvalid, 0);
      #1 rst_n = 1'b1;
      starve = 0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 8'h21, 1, 0, 8'(k + 40), 8'h00, gi, gd);
         checkOutput("t5_wait_cleared", i_gnt, (k == 4));
      end

      $display("[TB] alternating fetch/load");
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) applyStimulus(1, 8'($urandom), 0, 0, 8'h00, 8'h00, gi, gd);
         else            applyStimulus(0, 8'h00, 1, 0, 8'($urandom), 8'h00, gi, gd);
      end

      $display("[TB] random traffic");
      ip = 0; dp = 0; dw = 0; ia = 0; da = 0; wd = 0;
      for (int n = 0; n < 400; n++) begin
         if (!ip) begin
            ip = ($urandom_range(0, 3) != 0);
            ia = 8'($urandom);
         end
         if (!dp) begin
            dp = ($urandom_range(0, 3) != 0);
            dw = 1'($urandom);
            da = 8'($urandom);
            wd = 8'($urandom);
         end
         applyStimulus(ip, ia, dp, dw, da, wd, gi, gd);
         if (gi) ip = 0;
         if (gd) dp = 0;
      end

      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      checkOutput("i_q_drained", i_q.size(), 0);
      checkOutput("d_q_drained", d_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
